mem_port_arbiter: RTL

//  Shares one single-port, fixed-latency unified memory between the IF stage (instruction fetch)
//  and the MEM stage (data load/store) of the 16-bit 5-stage pipeline.

---
 rtl/cpu_mem_pkg.sv | 15 +
 rtl/mem_lat_timer.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the unified-memory port of the 16-bit pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cpu_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // Arbiter FSM encoding, kept as plain constants so older blocks can share it.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE    = 2'd0;
    localparam arb_state_t BUSY_IF = 2'd1;
    localparam arb_state_t BUSY_DM = 2'd2;

endpackage

// File: rtl/mem_lat_timer.sv
// Counts the cycles of one memory transaction: 0 on the strobe cycle up to MEM_LAT on data return.
// Latency: start_o in the first busy cycle after a restart, done_o MEM_LAT cycles later.
// Backpressure: none; the timer free-runs while busy and is restarted by every grant.
module mem_lat_timer #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = $clog2(MEM_LAT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic busy_i,
    input  logic restart_i,
    output logic start_o,
    output logic done_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT);

    logic [CNT_W-1:0] lat_cnt_q;
    logic [CNT_W-1:0] lat_cnt_d;

    // Next count: a grant restarts at 0, otherwise step towards LAST while a transaction runs.
    always_comb begin
        lat_cnt_d = '0;
        if (restart_i) begin
            lat_cnt_d = '0;
        end else if (busy_i && (lat_cnt_q != LAST)) begin
            lat_cnt_d = lat_cnt_q + CNT_W'(1);
        end
    end

    // Counter register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt_q <= '0;
        end else begin
            lat_cnt_q <= lat_cnt_d;
        end
    end

    assign start_o = busy_i && (lat_cnt_q == '0);
    assign done_o  = busy_i && (lat_cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch and data access.
// Latency: request seen in cycle T -> mem_en in T+1 -> valid in T+1+MEM_LAT; back-to-back grants.
// Backpressure: losing/waiting stage is held via stall_if/stall_mem until its valid pulse.
module mem_port_arbiter import cpu_mem_pkg::*; #(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

    arb_state_t        state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;

    logic busy, start, done;
    logic if_done, dm_done;
    logic arb_en, if_cand, dm_cand;
    logic if_win, dm_win, grant;

    mem_lat_timer #(
        .MEM_LAT (MEM_LAT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .busy_i    (busy),
        .restart_i (grant),
        .start_o   (start),
        .done_o    (done)
    );

    assign busy    = (state_q != IDLE);
    assign if_done = done && (state_q == BUSY_IF);
    assign dm_done = done && (state_q == BUSY_DM);

    // The requester being completed still holds its req this cycle, so it is not a candidate.
    assign arb_en  = !busy || done;
    assign if_cand = if_req && !if_done;
    assign dm_cand = dm_req && !dm_done;
    assign if_win  = arb_en && if_cand && (!dm_cand || (starve_q == STARVE_LIM));
    assign dm_win  = arb_en && dm_cand && !if_win;
    assign grant   = if_win || dm_win;

    // Next state, grant capture and fetch-starvation tracking.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        starve_d = starve_q;

        if (if_win) begin
            state_d = BUSY_IF;
            addr_d  = if_addr;
            wdata_d = '0;
            we_d    = 1'b0;
        end else if (dm_win) begin
            state_d = BUSY_DM;
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
            we_d    = dm_we;
        end else if (done) begin
            state_d = IDLE;
        end

        // Count data grants taken while fetch was waiting; any fetch grant or idle fetch clears it.
        if (if_win || !if_req) begin
            starve_d = '0;
        end else if (dm_win && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // State and grant registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
        end
    end

    assign mem_en    = start;
    assign mem_we    = start && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_valid  = if_done;
    assign if_rdata  = if_done ? mem_rdata : '0;
    assign dm_valid  = dm_done;
    assign dm_rdata  = (dm_done && !we_q) ? mem_rdata : '0;

    assign stall_if  = if_req && !if_valid;
    assign stall_mem = dm_req && !dm_valid;

endmodule
